// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Drives the PLL reset input, synchronizes the asynchronous lock indication
// and holds the system reset until lock has been continuously stable for
// STABLE_CYCLES refclk cycles. Lock timeouts re-pulse the PLL reset and are
// counted. A lock loss while running re-pulses the PLL reset and sets a
// sticky flag.
`timescale 1ns/1ps
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 1000000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int RETRY_W        = 4
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               pll_locked,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic               lock_lost
);

   // One shared counter sized for the longest of the three intervals.
   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_ZERO  = {RETRY_W{1'b0}};
   localparam logic [RETRY_W-1:0] RETRY_ONE   = {{(RETRY_W-1){1'b0}}, 1'b1};
   localparam logic [RETRY_W-1:0] RETRY_MAX   = {RETRY_W{1'b1}};

   typedef enum logic [1:0] {
      ST_PLL_RESET = 2'd0,
      ST_WAIT_LOCK = 2'd1,
      ST_STABLE    = 2'd2,
      ST_RUN       = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RETRY_W-1:0] retry_q, retry_d;
   logic               lost_q, lost_d;
   logic               sync1_q, locked_s_q;
   logic               pll_rst_q, sys_rst_q, ready_q;

   // Two-flop synchronizer bringing the asynchronous lock flag into refclk.
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync1_q    <= pll_locked;
         locked_s_q <= sync1_q;
      end
   end

   // Next-state, counter, retry and lock-loss logic of the sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      case (state_q)
         ST_PLL_RESET: begin
            // Lock is ignored while the PLL is being held in reset.
            if (cnt_q == PLL_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_WAIT_LOCK: begin
            // Lock takes priority over a timeout reached in the same cycle.
            if (locked_s_q) begin
               state_d = ST_STABLE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = ST_PLL_RESET;
               cnt_d   = CNT_ZERO;
               if (retry_q != RETRY_MAX) begin
                  retry_d = retry_q + RETRY_ONE;
               end else begin
                  retry_d = retry_q;
               end
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_STABLE: begin
            // A drop restarts the lock wait without counting a retry.
            if (!locked_s_q) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         ST_RUN: begin
            if (!locked_s_q) begin
               state_d = ST_PLL_RESET;
               cnt_d   = CNT_ZERO;
               lost_d  = 1'b1;
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_PLL_RESET;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State register plus outputs registered from the next state, so they
   // track the state register with no extra cycle of latency.
   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q   <= ST_PLL_RESET;
         cnt_q     <= CNT_ZERO;
         retry_q   <= RETRY_ZERO;
         lost_q    <= 1'b0;
         pll_rst_q <= 1'b1;
         sys_rst_q <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         retry_q   <= retry_d;
         lost_q    <= lost_d;
         pll_rst_q <= (state_d == ST_PLL_RESET);
         sys_rst_q <= (state_d != ST_RUN);
         ready_q   <= (state_d == ST_RUN);
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst   = sys_rst_q;
   assign ready     = ready_q;
   assign retry_cnt = retry_q;
   assign lock_lost = lost_q;

endmodule
